// File: rtl/cpuconst_pkg.sv
// cpuconst: shared constants for the exception unit (ExcCodes, status bits, vectors).
package cpuconst;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_ERL = 2;
    localparam int ST_BEV = 22;

    localparam logic [63:0] VEC_BASE_BEV   = 64'hFFFF_FFFF_BFC0_0200;
    localparam logic [63:0] VEC_BASE_NORM  = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] VEC_OFF_REFILL = 64'h0;
    localparam logic [63:0] VEC_OFF_GEN    = 64'h180;

    typedef enum logic [1:0] {RUN, KILL, VEC} exc_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
    } exc_ent_t;

    // TLB refill misses get the dedicated offset only when not already at exception level
    function automatic logic [63:0] vec_target(input logic bev, input logic exl, input logic [4:0] code);
        return (bev ? VEC_BASE_BEV : VEC_BASE_NORM) +
               ((!exl && (code == EXC_TLBL || code == EXC_TLBS)) ? VEC_OFF_REFILL : VEC_OFF_GEN);
    endfunction

endpackage

// File: rtl/exc_chain.sv
// exc_chain: carries per-instruction exception {valid, code} from IC through RF and EX to DC.
module exc_chain
    import cpuconst::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phi2,
    input  logic       stall,
    input  logic       clr,
    input  logic       ic_req,
    input  logic [4:0] ic_code,
    input  logic       rf_req,
    input  logic [4:0] rf_code,
    input  logic       ex_req,
    input  logic [4:0] ex_code,
    output exc_ent_t   dc_ent
);

    exc_ent_t rf_q, rf_d, ex_q, ex_d, dc_q, dc_d;

    // An older entry already held for the instruction masks the current stage's request
    always_comb begin
        rf_d = rf_q;
        ex_d = ex_q;
        dc_d = dc_q;
        if (clr) begin
            rf_d = '0;
            ex_d = '0;
            dc_d = '0;
        end else if (!stall) begin
            rf_d = exc_ent_t'{ic_req, ic_code};
            ex_d = rf_q.valid ? rf_q : exc_ent_t'{rf_req, rf_code};
            dc_d = ex_q.valid ? ex_q : exc_ent_t'{ex_req, ex_code};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q <= '0;
            ex_q <= '0;
            dc_q <= '0;
        end else if (phi2) begin
            rf_q <= rf_d;
            ex_q <= ex_d;
            dc_q <= dc_d;
        end
    end

    assign dc_ent = dc_q;

endmodule

// File: rtl/exc_unit.sv
// exc_unit: exception prioritizer and RUN/KILL/VEC sequencer feeding CP0 and the fetch redirect.
// EXC_INTSYNC_EN adds a 2-flop synchronizer ahead of the interrupt pending register.
module exc_unit
    import cpuconst::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phi2,
    input  logic        stall,
    input  logic        ic_req,
    input  logic        rf_req,
    input  logic        ex_req,
    input  logic        dc_req,
    input  logic [4:0]  ic_code,
    input  logic [4:0]  rf_code,
    input  logic [4:0]  ex_code,
    input  logic [4:0]  dc_code,
    input  logic [63:0] dc_pc,
    input  logic        dc_bd,
    input  logic        eret,
    input  logic [4:0]  int_n,
    input  logic [31:0] cp0status,
    input  logic [31:0] cp0cause,
    input  logic [63:0] cp0epc,
    input  logic [63:0] cp0errorepc,
    output logic        cp0setexl,
    output logic [5:0]  cp0setexccode,
    output logic [65:0] cp0setepc,
    output logic        cp0setbadva,
    output logic        cp0setcontext,
    output logic        flush,
    output logic        redirect,
    output logic [63:0] redirect_pc
);

    exc_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] tgt_q, tgt_d, rpc_q, rpc_d;
    logic        setexl_q, setexl_d, badva_q, badva_d, ctx_q, ctx_d;
    logic        flush_q, flush_d, redir_q, redir_d;
    logic [5:0]  exccode_q, exccode_d;
    logic [65:0] epc_q, epc_d;
    logic [4:0]  ip_q, ip_d, code;
    logic [7:0]  ip_vec;
    logic        exl, erl, dc_exc, int_pend, take, do_eret, clr;
    logic        unused_bits;
    exc_ent_t    dc_ent;

    exc_chain u_chain (
        .clk     (clk),
        .rst_n   (rst_n),
        .phi2    (phi2),
        .stall   (stall),
        .clr     (clr),
        .ic_req  (ic_req),
        .ic_code (ic_code),
        .rf_req  (rf_req),
        .rf_code (rf_code),
        .ex_req  (ex_req),
        .ex_code (ex_code),
        .dc_ent  (dc_ent)
    );

`ifdef EXC_INTSYNC_EN
    logic [4:0] s1_q, s1_d, s2_q, s2_d;
    always_comb begin
        s1_d = ~int_n;
        s2_d = s1_q;
        ip_d = s2_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (phi2) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
`else
    always_comb ip_d = ~int_n;
`endif

    assign unused_bits = ^{cp0status[31:23], cp0status[21:16], cp0status[7:3],
                           cp0cause[31:16], cp0cause[14:10], cp0cause[7:0]};

    always_comb begin
        exl      = cp0status[ST_EXL];
        erl      = cp0status[ST_ERL];
        ip_vec   = {cp0cause[15], ip_q, cp0cause[9:8]};
        int_pend = cp0status[ST_IE] & ~exl & ~erl & |(ip_vec & cp0status[15:8]);
        dc_exc   = dc_ent.valid | dc_req;
        code     = dc_ent.valid ? dc_ent.code : dc_req ? dc_code : EXC_INT;
        take     = state_q == RUN && (dc_exc || int_pend);
        do_eret  = state_q == RUN && !take && eret;
        clr      = state_q != RUN || take || do_eret;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        rpc_d     = rpc_q;
        setexl_d  = 1'b0;
        exccode_d = '0;
        epc_d     = '0;
        badva_d   = 1'b0;
        ctx_d     = 1'b0;
        flush_d   = 1'b0;
        redir_d   = 1'b0;
        if (take) begin
            state_d   = KILL;
            cnt_d     = 2'd2;
            flush_d   = 1'b1;
            setexl_d  = 1'b1;
            exccode_d = {1'b1, code};
            epc_d     = {~exl, dc_bd, dc_bd ? dc_pc - 64'd4 : dc_pc};
            badva_d   = code >= EXC_MOD && code <= EXC_ADES;
            ctx_d     = code >= EXC_MOD && code <= EXC_TLBS;
            tgt_d     = vec_target(cp0status[ST_BEV], exl, code);
        end else if (do_eret) begin
            state_d = KILL;
            cnt_d   = 2'd2;
            flush_d = 1'b1;
            tgt_d   = erl ? cp0errorepc : cp0epc;
        end else if (state_q == KILL) begin
            state_d = cnt_q == 2'd0 ? VEC : KILL;
            cnt_d   = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
            flush_d = cnt_q != 2'd0;
            redir_d = cnt_q == 2'd0;
            rpc_d   = cnt_q == 2'd0 ? tgt_q : rpc_q;
        end else if (state_q == VEC) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            tgt_q     <= '0;
            rpc_q     <= '0;
            setexl_q  <= 1'b0;
            exccode_q <= '0;
            epc_q     <= '0;
            badva_q   <= 1'b0;
            ctx_q     <= 1'b0;
            flush_q   <= 1'b0;
            redir_q   <= 1'b0;
            ip_q      <= '0;
        end else if (phi2) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            rpc_q     <= rpc_d;
            setexl_q  <= setexl_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            badva_q   <= badva_d;
            ctx_q     <= ctx_d;
            flush_q   <= flush_d;
            redir_q   <= redir_d;
            ip_q      <= ip_d;
        end
    end

    assign cp0setexl     = setexl_q;
    assign cp0setexccode = exccode_q;
    assign cp0setepc     = epc_q;
    assign cp0setbadva   = badva_q;
    assign cp0setcontext = ctx_q;
    assign flush         = flush_q;
    assign redirect      = redir_q;
    assign redirect_pc   = rpc_q;

endmodule

// File: tb/tb_exc_unit.sv
// tb_exc_unit: directed stimulus for exc_unit, checked every tick against a timeline model
// plus hand-computed literal expectations.
module tb_exc_unit;

`ifdef EXC_INTSYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 0, rst_n = 0, phi2 = 1, stall = 0;
    logic        ic_req = 0, rf_req = 0, ex_req = 0, dc_req = 0, dc_bd = 0, eret = 0;
    logic [4:0]  ic_code = 0, rf_code = 0, ex_code = 0, dc_code = 0, int_n = 5'h1f;
    logic [63:0] dc_pc = 0, cp0epc = 0, cp0errorepc = 0;
    logic [31:0] cp0status = 0, cp0cause = 0;
    logic        cp0setexl, cp0setbadva, cp0setcontext, flush, redirect;
    logic [5:0]  cp0setexccode;
    logic [65:0] cp0setepc;
    logic [63:0] redirect_pc;

    int checks = 0, failures = 0;

    exc_unit dut (
        .clk(clk), .rst_n(rst_n), .phi2(phi2), .stall(stall),
        .ic_req(ic_req), .rf_req(rf_req), .ex_req(ex_req), .dc_req(dc_req),
        .ic_code(ic_code), .rf_code(rf_code), .ex_code(ex_code), .dc_code(dc_code),
        .dc_pc(dc_pc), .dc_bd(dc_bd), .eret(eret), .int_n(int_n),
        .cp0status(cp0status), .cp0cause(cp0cause), .cp0epc(cp0epc), .cp0errorepc(cp0errorepc),
        .cp0setexl(cp0setexl), .cp0setexccode(cp0setexccode), .cp0setepc(cp0setepc),
        .cp0setbadva(cp0setbadva), .cp0setcontext(cp0setcontext),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: per-stage pending code (-1 = none) and ticks elapsed since entering a sequence
    int          prf = -1, pex = -1, pdc = -1, seq = 0;
    logic [4:0]  h [0:2] = '{default: 5'd0};
    logic [63:0] tgt = 0, m_rpc = 0;
    logic        m_exl = 0, m_badva = 0, m_ctx = 0, m_flush = 0, m_redir = 0;
    logic [5:0]  m_code = 0;
    logic [65:0] m_epc = 0;

    task automatic model_reset();
        prf = -1; pex = -1; pdc = -1; seq = 0;
        h[0] = 0; h[1] = 0; h[2] = 0;
        tgt = 0; m_rpc = 0; m_exl = 0; m_badva = 0; m_ctx = 0;
        m_flush = 0; m_redir = 0; m_code = 0; m_epc = 0;
    endtask

    task automatic model_step();
        int dcx, c;
        logic [4:0] ipn;
        logic [7:0] ipv;
        logic pend, exl, erl, bev;
        ipn = h[LAT-1];
        h[2] = h[1]; h[1] = h[0]; h[0] = ~int_n;
        m_exl = 0; m_code = 0; m_epc = 0; m_badva = 0; m_ctx = 0; m_flush = 0; m_redir = 0;
        if (seq != 0) begin
            seq = (seq == 4) ? 0 : seq + 1;
            m_flush = seq >= 1 && seq <= 3;
            if (seq == 4) begin
                m_redir = 1;
                m_rpc = tgt;
            end
            prf = -1; pex = -1; pdc = -1;
        end else begin
            exl = cp0status[1]; erl = cp0status[2]; bev = cp0status[22];
            ipv = {cp0cause[15], ipn, cp0cause[9:8]};
            pend = cp0status[0] && !exl && !erl && ((ipv & cp0status[15:8]) != 0);
            dcx = pdc >= 0 ? pdc : dc_req ? int'(dc_code) : -1;
            if (dcx >= 0 || pend) begin
                c = dcx >= 0 ? dcx : 0;
                m_exl = 1;
                m_code = {1'b1, 5'(c)};
                m_epc = {!exl, dc_bd, dc_bd ? dc_pc - 64'd4 : dc_pc};
                m_badva = c >= 1 && c <= 5;
                m_ctx = c >= 1 && c <= 3;
                tgt = (bev ? 64'hFFFFFFFF_BFC00200 : 64'hFFFFFFFF_80000000) +
                      (((c == 2 || c == 3) && !exl) ? 64'h0 : 64'h180);
                seq = 1; m_flush = 1;
                prf = -1; pex = -1; pdc = -1;
            end else if (eret) begin
                tgt = erl ? cp0errorepc : cp0epc;
                seq = 1; m_flush = 1;
                prf = -1; pex = -1; pdc = -1;
            end else if (!stall) begin
                pdc = pex >= 0 ? pex : ex_req ? int'(ex_code) : -1;
                pex = prf >= 0 ? prf : rf_req ? int'(rf_code) : -1;
                prf = ic_req ? int'(ic_code) : -1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else if (phi2) model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        chk("cmp_setexl", cp0setexl, m_exl);
        chk("cmp_exccode", cp0setexccode, m_code);
        chk("cmp_epc", cp0setepc, m_epc);
        chk("cmp_badva", cp0setbadva, m_badva);
        chk("cmp_context", cp0setcontext, m_ctx);
        chk("cmp_flush", flush, m_flush);
        chk("cmp_redirect", redirect, m_redir);
        chk("cmp_rpc", redirect_pc, m_rpc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_epc", cp0setepc, 0);
        chk("rst_rpc", redirect_pc, 0);
        rst_n = 1;
        tick(2);

        // general exception from EX, reported two ticks later
        dc_pc = 64'hFFFFFFFF_80001000;
        ex_req = 1; ex_code = 12;
        tick(1); ex_req = 0;
        tick(1);
        chk("t1_code", cp0setexccode, 6'h2C);
        chk("t1_epc", cp0setepc, {2'b10, 64'hFFFFFFFF_80001000});
        chk("t1_flush0", flush, 1);
        tick(1);
        chk("t1_pulse_end", cp0setexl, 0);
        chk("t1_flush1", flush, 1);
        tick(1);
        chk("t1_flush2", flush, 1);
        tick(1);
        chk("t1_flush_off", flush, 0);
        chk("t1_redirect", redirect, 1);
        chk("t1_rpc", redirect_pc, 64'hFFFFFFFF_80000180);
        tick(1);
        chk("t1_redirect_end", redirect, 0);
        chk("t1_rpc_hold", redirect_pc, 64'hFFFFFFFF_80000180);
        tick(1);

        // TLB refill in a delay slot
        dc_pc = 64'hFFFFFFFF_80002004; dc_bd = 1;
        dc_req = 1; dc_code = 2;
        tick(1); dc_req = 0;
        chk("t2_code", cp0setexccode, 6'h22);
        chk("t2_epc", cp0setepc, {2'b11, 64'hFFFFFFFF_80002000});
        chk("t2_badva", cp0setbadva, 1);
        chk("t2_context", cp0setcontext, 1);
        tick(3);
        chk("t2_rpc", redirect_pc, 64'hFFFFFFFF_80000000);
        dc_bd = 0;
        tick(2);

        // older IC exception wins over a later EX request for the same instruction
        ic_req = 1; ic_code = 4;
        tick(1); ic_req = 0;
        tick(1); ex_req = 1; ex_code = 12;
        tick(1); ex_req = 0;
        tick(1);
        chk("t3_code", cp0setexccode, 6'h24);
        chk("t3_badva", cp0setbadva, 1);
        chk("t3_context", cp0setcontext, 0);
        tick(5);

        // stall holds the chain; a request during stall is not latched
        ic_req = 1; ic_code = 5;
        tick(1); ic_req = 0; stall = 1; rf_req = 1; rf_code = 1;
        tick(2); stall = 0; rf_req = 0;
        tick(10);

        // refill with EXL=1 and BEV=1, with phi2 gaps inside the sequence
        cp0status = 32'h0040_0002;
        dc_req = 1; dc_code = 3;
        tick(1); dc_req = 0;
        chk("t5_epc_exl", cp0setepc[65], 0);
        phi2 = 0;
        tick(3); phi2 = 1;
        tick(6);
        chk("t5_rpc", redirect_pc, 64'hFFFFFFFF_BFC00380);
        cp0status = 0;
        tick(2);

        // interrupt taken, then masked by EXL
        cp0status = 32'h0000_0401; int_n = 5'b11110;
        tick(LAT + 1);
        chk("t6_code", cp0setexccode, 6'h20);
        chk("t6_setexl", cp0setexl, 1);
        int_n = 5'h1f; cp0status = 0;
        tick(6);
        cp0status = 32'h0000_0403; int_n = 5'b11110;
        tick(8);
        chk("t6_exl_flush", flush, 0);
        chk("t6_exl_setexl", cp0setexl, 0);
        int_n = 5'h1f;
        tick(LAT + 2);
        cp0status = 0;
        tick(2);

        // eret with ERL=1 returns to ErrorEPC, no CP0 updates
        cp0status = 32'h0000_0004; cp0errorepc = 64'hFFFFFFFF_BFC00000; cp0epc = 64'hFFFFFFFF_80001234;
        eret = 1;
        tick(1); eret = 0;
        chk("t7_setexl", cp0setexl, 0);
        chk("t7_exccode", cp0setexccode, 0);
        chk("t7_flush", flush, 1);
        tick(3);
        chk("t7_redirect", redirect, 1);
        chk("t7_rpc", redirect_pc, 64'hFFFFFFFF_BFC00000);
        tick(2);
        cp0status = 0;
        eret = 1;
        tick(1); eret = 0;
        tick(5);
        chk("t7b_rpc", redirect_pc, 64'hFFFFFFFF_80001234);

        // DC exception beats simultaneous interrupt and eret
        cp0status = 32'h0000_0400; int_n = 5'b11110;
        tick(LAT + 1);
        cp0status = 32'h0000_0401; dc_req = 1; dc_code = 4; eret = 1;
        tick(1); dc_req = 0; eret = 0; int_n = 5'h1f; cp0status = 0;
        chk("t9_code", cp0setexccode, 6'h24);
        tick(8);

        // reset during the second KILL tick abandons the sequence
        dc_req = 1; dc_code = 12;
        tick(1); dc_req = 0;
        tick(1);
        chk("t8_flush_pre", flush, 1);
        rst_n = 0;
        #1;
        chk("t8_flush_async", flush, 0);
        tick(2); rst_n = 1;
        tick(6);
        chk("t8_no_redirect", redirect, 0);
        chk("t8_rpc", redirect_pc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
